// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: opcodes, instruction field positions
// and fetch FSM state encodings.
package fetch_unit_pkg;

    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_LOD  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_BRA  = 4'h4;
    localparam logic [3:0] OP_BRR  = 4'h5;
    localparam logic [3:0] OP_BNE  = 4'h6;
    localparam logic [3:0] OP_ALU  = 4'h8;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int OFF_HI = 15;
    localparam int OFF_LO = 0;
    localparam int OFF_W  = OFF_HI - OFF_LO + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic              IMEM_REQ;
    logic              IMEM_VALID;
    logic [DATA_W-1:0] IMEM_DATA;

    modport master (
        output IMEM_ADDR,
        output IMEM_REQ,
        input  IMEM_VALID,
        input  IMEM_DATA
    );

    modport slave (
        input  IMEM_ADDR,
        input  IMEM_REQ,
        output IMEM_VALID,
        output IMEM_DATA
    );
endinterface

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: hold, increment, absolute or PC-relative
// branch, with synchronous-clear priority. All arithmetic wraps at ADDR_W bits.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] ir_abs,
    input  logic [OFF_W-1:0]  ir_off,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic              br_sel,
    input  logic              pc_rst,
    output logic [ADDR_W-1:0] pc_nxt
);

    logic [ADDR_W-1:0] off_ext_s;
    logic [ADDR_W-1:0] target_s;

    // Branch target and next-PC priority mux
    always_comb begin
        off_ext_s = ADDR_W'($signed(ir_off));
        target_s  = br_sel ? (pc + off_ext_s) : ir_abs;
        pc_nxt    = pc;
        if (pc_rst) begin
            pc_nxt = RESET_PC;
        end else if (pc_write) begin
            pc_nxt = pc_sel ? target_s : (pc + ADDR_W'(1));
        end else begin
            pc_nxt = pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, IR and STAT registers plus a two-state fetch FSM that
// issues a held request to instruction memory and times out into a noop.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FETCH,
    input  logic              PC_WRITE,
    input  logic              PC_SEL,
    input  logic              BR_SEL,
    input  logic              PC_RST,
    input  logic              STAT_WE,
    input  logic [3:0]        FLAGS_IN,
    fetch_unit_if.master      imem,
    output logic [DATA_W-1:0] IR,
    output logic [3:0]        OPCODE,
    output logic [3:0]        MM,
    output logic [3:0]        STAT,
    output logic [ADDR_W-1:0] PC,
    output logic              IR_VALID,
    output logic              BUSY,
    output logic              FAULT
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e      state_r,  state_nxt_s;
    logic [CNT_W-1:0]  cnt_r,    cnt_nxt_s;
    logic [DATA_W-1:0] ir_r,     ir_nxt_s;
    logic              irv_r,    irv_nxt_s;
    logic              fault_r,  fault_nxt_s;
    logic              busy_r,   busy_nxt_s;
    logic [ADDR_W-1:0] addr_r,   addr_nxt_s;
    logic [ADDR_W-1:0] pc_r,     pc_nxt_s;
    logic [3:0]        stat_r;

    fetch_unit_pc_next #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_next (
        .pc       (pc_r),
        .ir_abs   (ir_r[ADDR_W-1:0]),
        .ir_off   (ir_r[OFF_HI:OFF_LO]),
        .pc_write (PC_WRITE),
        .pc_sel   (PC_SEL),
        .br_sel   (BR_SEL),
        .pc_rst   (PC_RST),
        .pc_nxt   (pc_nxt_s)
    );

    // Fetch FSM next-state and registered-output next values
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ir_nxt_s    = ir_r;
        irv_nxt_s   = 1'b0;
        fault_nxt_s = fault_r;
        busy_nxt_s  = busy_r;
        addr_nxt_s  = addr_r;
        case (state_r)
            ST_IDLE: begin
                if (FETCH) begin
                    state_nxt_s = ST_WAIT;
                    addr_nxt_s  = pc_r;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_WAIT: begin
                // Valid data on the final wait cycle still beats the timeout
                if (imem.IMEM_VALID) begin
                    state_nxt_s = ST_IDLE;
                    ir_nxt_s    = imem.IMEM_DATA;
                    irv_nxt_s   = 1'b1;
                    busy_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(TIMEOUT)) begin
                    state_nxt_s = ST_IDLE;
                    ir_nxt_s    = {DATA_W{1'b0}};
                    irv_nxt_s   = 1'b1;
                    fault_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            ir_r    <= {DATA_W{1'b0}};
            irv_r   <= 1'b0;
            fault_r <= 1'b0;
            busy_r  <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            pc_r    <= RESET_PC;
            stat_r  <= 4'h0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ir_r    <= ir_nxt_s;
            irv_r   <= irv_nxt_s;
            fault_r <= fault_nxt_s;
            busy_r  <= busy_nxt_s;
            addr_r  <= addr_nxt_s;
            pc_r    <= pc_nxt_s;
            stat_r  <= STAT_WE ? FLAGS_IN : stat_r;
        end
    end

    assign imem.IMEM_ADDR = addr_r;
    assign imem.IMEM_REQ  = busy_r;
    assign IR             = ir_r;
    assign OPCODE         = ir_r[OPC_HI:OPC_LO];
    assign MM             = ir_r[MM_HI:MM_LO];
    assign STAT           = stat_r;
    assign PC             = pc_r;
    assign IR_VALID       = irv_r;
    assign BUSY           = busy_r;
    assign FAULT          = fault_r;

endmodule
